// File: rtl/video_pattern_source_if.sv
// AXI4-Stream video beat bundle: pixel data plus valid/ready handshake and framing flags.
interface video_pattern_source_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/video_pattern_source.sv
// Self-timed AXI4-Stream test-pattern frame source (solid, ramp, colour bars, checker).
// Config is shadowed once per frame; all stream outputs come straight from flops.
module video_pattern_source #(
  parameter int unsigned MAXWIDTH  = 1280,
  parameter int unsigned MAXHEIGHT = 1024
) (
  input  logic                          m_axis_vid_aclk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [11:0]                   cfg_width,
  input  logic [11:0]                   cfg_height,
  input  logic [1:0]                    cfg_pattern,
  input  logic [23:0]                   cfg_color,
  video_pattern_source_if.master        m_axis_vid,
  output logic [15:0]                   frame_count,
  output logic                          busy
);

  localparam logic [11:0] MaxW = 12'(MAXWIDTH);
  localparam logic [11:0] MaxH = 12'(MAXHEIGHT);

  typedef enum logic [1:0] {StIdle, StLatch, StStream} state_e;

  state_e      state_q, state_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [11:0] w_q, w_d, h_q, h_d;
  logic [1:0]  pattern_q, pattern_d;
  logic [23:0] color_q, color_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        busy_q, busy_d;

  logic [11:0] w_clamp, h_clamp;
  logic [11:0] x_nxt, y_nxt;
  logic        last_x, last_y;

  // Pixel colour for a given beat position.
  function automatic logic [31:0] pixel_f(input logic [11:0] x, input logic [11:0] y,
                                          input logic [1:0] pat, input logic [23:0] col);
    logic [31:0] px;
    logic [2:0]  bar;
    px  = 32'h0;
    bar = x[9:7];
    case (pat)
      2'd0:    px = {8'h00, col};
      2'd1:    px = {8'h00, x[7:0], x[7:0], x[7:0]};
      2'd2:    px = {8'h00, {8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
      default: px = (x[4] ^ y[4]) ? {8'h00, col} : 32'h0;
    endcase
    return px;
  endfunction

  // Zero-size requests become 1, oversize requests saturate at the maximum.
  always_comb begin
    w_clamp = (cfg_width == 12'd0) ? 12'd1 : ((cfg_width > MaxW) ? MaxW : cfg_width);
    h_clamp = (cfg_height == 12'd0) ? 12'd1 : ((cfg_height > MaxH) ? MaxH : cfg_height);
  end

  // Next-state: frame sequencing, raster position and next beat's registered outputs.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    w_d           = w_q;
    h_d           = h_q;
    pattern_d     = pattern_q;
    color_d       = color_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    frame_count_d = frame_count_q;
    last_x        = (x_q == (w_q - 12'd1));
    last_y        = (y_q == (h_q - 12'd1));
    x_nxt         = last_x ? 12'd0 : (x_q + 12'd1);
    y_nxt         = last_x ? (y_q + 12'd1) : y_q;

    unique case (state_q)
      StIdle: begin
        tvalid_d = 1'b0;
        if (enable) state_d = StLatch;
      end
      StLatch: begin
        w_d       = w_clamp;
        h_d       = h_clamp;
        pattern_d = cfg_pattern;
        color_d   = cfg_color;
        x_d       = 12'd0;
        y_d       = 12'd0;
        tdata_d   = pixel_f(12'd0, 12'd0, cfg_pattern, cfg_color);
        tuser_d   = 1'b1;
        tlast_d   = (w_clamp == 12'd1);
        tvalid_d  = 1'b1;
        state_d   = StStream;
      end
      StStream: begin
        if (tvalid_q && m_axis_vid.tready) begin
          if (last_x && last_y) begin
            // Frame done: one idle beat (LATCH or IDLE) always follows.
            frame_count_d = frame_count_q + 16'd1;
            tvalid_d      = 1'b0;
            tuser_d       = 1'b0;
            tlast_d       = 1'b0;
            x_d           = 12'd0;
            y_d           = 12'd0;
            state_d       = enable ? StLatch : StIdle;
          end else begin
            x_d     = x_nxt;
            y_d     = y_nxt;
            tdata_d = pixel_f(x_nxt, y_nxt, pattern_q, color_q);
            tuser_d = (x_nxt == 12'd0) && (y_nxt == 12'd0);
            tlast_d = (x_nxt == (w_q - 12'd1));
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge m_axis_vid_aclk) begin
    if (reset) begin
      state_q       <= StIdle;
      x_q           <= 12'd0;
      y_q           <= 12'd0;
      w_q           <= 12'd1;
      h_q           <= 12'd1;
      pattern_q     <= 2'd0;
      color_q       <= 24'h0;
      tdata_q       <= 32'h0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      frame_count_q <= 16'h0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      w_q           <= w_d;
      h_q           <= h_d;
      pattern_q     <= pattern_d;
      color_q       <= color_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
    end
  end

  assign m_axis_vid.tdata  = tdata_q;
  assign m_axis_vid.tvalid = tvalid_q;
  assign m_axis_vid.tlast  = tlast_q;
  assign m_axis_vid.tuser  = tuser_q;
  assign frame_count       = frame_count_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Bench for video_pattern_source: expected beats come from a raster-scan model of each frame.
module tb_video_pattern_source;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic [1:0]  cfg_pattern;
  logic [23:0] cfg_color;
  logic [15:0] frame_count;
  logic        busy;

  video_pattern_source_if vid_if ();

  video_pattern_source dut (
    .m_axis_vid_aclk (clk),
    .reset           (reset),
    .enable          (enable),
    .cfg_width       (cfg_width),
    .cfg_height      (cfg_height),
    .cfg_pattern     (cfg_pattern),
    .cfg_color       (cfg_color),
    .m_axis_vid      (vid_if),
    .frame_count     (frame_count),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        user;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    vectors    = 0;
  int    miscompares = 0;
  int    fc_exp     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference colour of pixel (x,y), straight from the pattern definitions.
  function automatic logic [31:0] model_pixel(input int x, input int y, input int pat,
                                              input logic [23:0] col);
    logic [7:0] v;
    case (pat)
      0: return {8'h00, col};
      1: begin
        v = 8'(x % 256);
        return {8'h00, v, v, v};
      end
      2: begin
        case ((x / 128) % 8)
          0: return 32'h00FFFFFF;
          1: return 32'h00FFFF00;
          2: return 32'h0000FFFF;
          3: return 32'h0000FF00;
          4: return 32'h00FF00FF;
          5: return 32'h00FF0000;
          6: return 32'h000000FF;
          default: return 32'h00000000;
        endcase
      end
      default: return ((((x / 16) + (y / 16)) % 2) == 1) ? {8'h00, col} : 32'h0;
    endcase
  endfunction

  task automatic push_frames(input int w, input int h, input int pat, input logic [23:0] col,
                             input int n);
    int wc, hc;
    beat_t b;
    wc = (w == 0) ? 1 : ((w > 1280) ? 1280 : w);
    hc = (h == 0) ? 1 : ((h > 1024) ? 1024 : h);
    for (int f = 0; f < n; f++)
      for (int y = 0; y < hc; y++)
        for (int x = 0; x < wc; x++) begin
          b.data = model_pixel(x, y, pat, col);
          b.user = (x == 0) && (y == 0);
          b.last = (x == wc - 1);
          exp_q.push_back(b);
        end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consume the expected beats. Caller sits #1 after an edge. mode: 0 ready, 1 = 1,0,0 cycle,
  // 2 = random. When stop_at beats have been accepted, enable drops (and colour may change).
  task automatic collect(input int budget, input int mode, input int stop_at,
                         input bit change_col, input logic [23:0] new_col);
    int          cycles, accepted, gap;
    bit          started, stalled, rdy;
    logic [31:0] h_data;
    logic        h_user, h_last;
    beat_t       e;
    cycles = 0; accepted = 0; gap = 0; started = 0; stalled = 0;
    h_data = '0; h_user = 1'b0; h_last = 1'b0;
    while (exp_q.size() > 0 && cycles < budget) begin
      if (stalled) begin
        chk("stall_tvalid", 32'(vid_if.tvalid), 32'd1);
        chk("stall_tdata", vid_if.tdata, h_data);
        chk("stall_tuser", 32'(vid_if.tuser), 32'(h_user));
        chk("stall_tlast", 32'(vid_if.tlast), 32'(h_last));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cycles % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      vid_if.tready = rdy;
      if (vid_if.tvalid) begin
        if (started && gap != 0) chk("frame_gap", 32'(gap), 32'd1);
        gap     = 0;
        started = 1'b1;
        if (rdy) begin
          e = exp_q.pop_front();
          chk("tdata", vid_if.tdata, e.data);
          chk("tuser", 32'(vid_if.tuser), 32'(e.user));
          chk("tlast", 32'(vid_if.tlast), 32'(e.last));
          accepted++;
          if (accepted == stop_at) begin
            enable = 1'b0;
            if (change_col) cfg_color = new_col;
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          h_data  = vid_if.tdata;
          h_user  = vid_if.tuser;
          h_last  = vid_if.tlast;
        end
      end else if (started) begin
        gap++;
      end
      cycles++;
      step();
    end
    chk("frame_done_remaining", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    vid_if.tready = 1'b1;
  endtask

  task automatic check_idle();
    for (int i = 0; i < 3; i++) begin
      chk("idle_tvalid", 32'(vid_if.tvalid), 32'd0);
      step();
    end
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic set_cfg(input int w, input int h, input int pat, input logic [23:0] col);
    cfg_width   = 12'(w);
    cfg_height  = 12'(h);
    cfg_pattern = 2'(pat);
    cfg_color   = col;
  endtask

  initial begin
    int n;
    int w, h, pat;
    logic [23:0] col;

    reset = 1'b1; enable = 1'b0; vid_if.tready = 1'b1;
    set_cfg(4, 2, 0, 24'h123456);
    step(); step();
    chk("rst_tvalid", 32'(vid_if.tvalid), 32'd0);
    chk("rst_tuser", 32'(vid_if.tuser), 32'd0);
    chk("rst_tlast", 32'(vid_if.tlast), 32'd0);
    chk("rst_tdata", vid_if.tdata, 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    // Basic framing with a one-cycle enable pulse and latency check.
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk("latch_tvalid", 32'(vid_if.tvalid), 32'd0);
    chk("latch_busy", 32'(busy), 32'd1);
    step();
    chk("first_tvalid", 32'(vid_if.tvalid), 32'd1);
    push_frames(4, 2, 0, 24'h123456, 1);
    collect(40, 0, 0, 1'b0, 24'h0);
    fc_exp++;
    chk("fc_basic", 32'(frame_count), 32'(fc_exp));
    check_idle();

    // Backpressure on a ramp line.
    set_cfg(4, 1, 1, 24'h0);
    enable = 1'b1; step();
    push_frames(4, 1, 1, 24'h0, 1);
    collect(60, 1, 1, 1'b0, 24'h0);
    fc_exp++;
    chk("fc_backpressure", 32'(frame_count), 32'(fc_exp));
    check_idle();

    // Colour bars across 1024 pixels.
    set_cfg(1024, 1, 2, 24'h0);
    enable = 1'b1; step();
    push_frames(1024, 1, 2, 24'h0, 1);
    collect(1100, 0, 1, 1'b0, 24'h0);
    fc_exp++;
    chk("fc_bars", 32'(frame_count), 32'(fc_exp));
    check_idle();

    // Mid-frame stop and colour change: frame completes with the old colour.
    set_cfg(8, 4, 0, 24'h5A5A5A);
    enable = 1'b1; step();
    push_frames(8, 4, 0, 24'h5A5A5A, 1);
    collect(200, 2, 10, 1'b1, 24'hABCDEF);
    fc_exp++;
    chk("fc_midstop", 32'(frame_count), 32'(fc_exp));
    check_idle();

    // Continuous run: three 2x2 frames, one bubble between each.
    set_cfg(2, 2, 1, 24'h0);
    enable = 1'b1; step();
    push_frames(2, 2, 1, 24'h0, 3);
    collect(200, 0, 9, 1'b0, 24'h0);
    fc_exp += 3;
    chk("fc_continuous", 32'(frame_count), 32'(fc_exp));
    check_idle();

    // Reset during beat 5 of a frame.
    set_cfg(8, 2, 0, 24'h00FF00);
    enable = 1'b1; step();
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (vid_if.tvalid) begin
        if (n == 5) break;
        n++;
      end
      step();
    end
    chk("beats_before_reset", 32'(n), 32'd5);
    reset = 1'b1; enable = 1'b0;
    step();
    reset = 1'b0;
    chk("midrst_tvalid", 32'(vid_if.tvalid), 32'd0);
    chk("midrst_frame_count", 32'(frame_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    fc_exp = 0;
    step();

    // Zero size clamps to 1x1 frames, back to back.
    set_cfg(0, 0, 3, 24'hFFFFFF);
    enable = 1'b1; step();
    push_frames(0, 0, 3, 24'hFFFFFF, 3);
    collect(40, 0, 3, 1'b0, 24'h0);
    fc_exp += 3;
    chk("fc_clamp_zero", 32'(frame_count), 32'(fc_exp));
    check_idle();

    // Oversize width clamps to 1280.
    set_cfg(4000, 2, 1, 24'h0);
    enable = 1'b1; step();
    push_frames(4000, 2, 1, 24'h0, 1);
    collect(2700, 0, 1, 1'b0, 24'h0);
    fc_exp++;
    chk("fc_clamp_max", 32'(frame_count), 32'(fc_exp));
    check_idle();

    // Random configurations with random backpressure.
    for (int r = 0; r < 4; r++) begin
      w   = $urandom_range(1, 40);
      h   = $urandom_range(1, 20);
      pat = $urandom_range(0, 3);
      col = 24'($urandom);
      set_cfg(w, h, pat, col);
      enable = 1'b1; step();
      push_frames(w, h, pat, col, 1);
      collect(w * h * 6 + 20, 2, 1, 1'b0, 24'h0);
      fc_exp++;
      chk("fc_random", 32'(frame_count), 32'(fc_exp));
      check_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
